// File: rtl/sincronizador_pkg.sv
// Shared types and 100 MHz defaults for the multi-channel
// button synchroniser / debouncer.
package sincronizador_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // 1 ms debounce and 0.5 s long press at 100 MHz
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/sincronizador_debounce_ch.sv
// One channel: sync chain, stability counter, long-press
// counter and registered edge flags.
module debounce_ch
  import sincronizador_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int   LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter logic INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_p,
  output logic rise_d,
  output logic fall_d
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [HW-1:0]          hcnt;
  logic                   s;
  logic                   done;

  assign s      = sync[SYNC_STAGES-1];
  assign done   = (s != level) &&
                  (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise_d = done & s;
  assign fall_d = done & ~s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      hcnt   <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      long_p <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], button ^ INVERT};
      rise   <= rise_d;
      fall   <= fall_d;
      long_p <= 1'b0;

      if (s == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // A release landing on the final count wins over long press
      if (!level || fall_d) begin
        hcnt <= '0;
      end else if (hcnt == HW'(LONG_CYCLES - 1)) begin
        long_p <= 1'b1;
        hcnt   <= HW'(LONG_CYCLES);
      end else if (hcnt < HW'(LONG_CYCLES - 1)) begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sincronizador_debounce.sv
// N_CH independent debounced button channels with edge,
// combined-edge and long-press pulses.
module sincronizador_debounce
  import sincronizador_pkg::*;
#(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int              DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int              LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int              EDGE_MODE       = 0,
  parameter logic [N_CH-1:0] INVERT          = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] long_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("EDGE_MODE must be 0, 1 or 2");
  end

  logic [N_CH-1:0] rise_d;
  logic [N_CH-1:0] fall_d;
  logic [N_CH-1:0] pulse_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .INVERT         (INVERT[c])
    ) u_ch (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .button(button_i[c]),
      .level (level_o[c]),
      .rise  (rise_o[c]),
      .fall  (fall_o[c]),
      .long_p(long_o[c]),
      .rise_d(rise_d[c]),
      .fall_d(fall_d[c])
    );
  end

  // Mux the next-state flags so pulse_o lines up with rise/fall
  if (EDGE_MODE == int'(EDGE_FALL)) begin : g_fall
    assign pulse_d = fall_d;
  end else if (EDGE_MODE == int'(EDGE_BOTH)) begin : g_both
    assign pulse_d = rise_d | fall_d;
  end else begin : g_rise
    assign pulse_d = rise_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pulse_o <= '0;
    end else begin
      pulse_o <= pulse_d;
    end
  end

endmodule

// File: tb/tb_sincronizador_debounce.sv
// Self-checking bench: directed scenarios plus random
// stimulus against a run-length reference model.
module tb_sincronizador_debounce;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int D  = 4;
  localparam int L  = 10;
  localparam logic [3:0] INV  = 4'b1000;
  localparam logic [3:0] IDLE = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic [3:0] button_i;
  logic [3:0] level_o, rise_o, fall_o, pulse_o, long_o;
  logic [19:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  sincronizador_debounce #(
    .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L), .EDGE_MODE(2), .INVERT(INV)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .button_i(button_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .pulse_o(pulse_o), .long_o(long_o)
  );

  always #5 clk = ~clk;

  assign obs = {level_o, rise_o, fall_o, pulse_o, long_o};

  // Reference model: delay line, then "differs for D cycles"
  // and "high for L cycles" run lengths.
  bit   dly [N][$];
  bit   m_lvl [N];
  int   m_run [N];
  int   m_high [N];
  bit   m_fired [N];
  logic [3:0] e_lvl, e_rise, e_fall, e_long;

  function automatic void m_reset();
    for (int c = 0; c < N; c++) begin
      dly[c] = {};
      for (int i = 0; i < SS; i++) dly[c].push_back(1'b0);
      m_lvl[c] = 0; m_run[c] = 0;
      m_high[c] = 0; m_fired[c] = 0;
    end
    e_lvl = '0; e_rise = '0; e_fall = '0; e_long = '0;
  endfunction

  function automatic void m_step(input logic [3:0] raw);
    for (int c = 0; c < N; c++) begin
      bit s, nl;
      s  = dly[c][0];
      nl = m_lvl[c];
      e_rise[c] = 0; e_fall[c] = 0; e_long[c] = 0;
      m_run[c] = (s != m_lvl[c]) ? m_run[c] + 1 : 0;
      if (m_run[c] == D) begin
        nl = s; m_run[c] = 0;
        e_rise[c] = s; e_fall[c] = !s;
      end
      if (m_lvl[c] && nl) begin
        m_high[c]++;
        if (m_high[c] == L && !m_fired[c]) begin
          e_long[c] = 1; m_fired[c] = 1;
        end
      end else begin
        m_high[c] = 0; m_fired[c] = 0;
      end
      void'(dly[c].pop_front());
      dly[c].push_back(raw[c] ^ INV[c]);
      m_lvl[c] = nl;
      e_lvl[c] = nl;
    end
  endfunction

  function automatic logic [19:0] exp_vec();
    return {e_lvl, e_rise, e_fall, e_rise | e_fall, e_long};
  endfunction

  task automatic tick(input logic [3:0] b);
    @(negedge clk);
    button_i = b;
    @(posedge clk);
    if (rst_n_i) m_step(b);
    else m_reset();
    #1;
    cyc++;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick(IDLE);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    button_i = 4'b1111;
    #3;
    n_cmp++;
    if (obs !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_async got %h want 0", obs);
    end
    for (int k = 0; k < 3; k++) begin
      tick(4'b1111);
      n_cmp++;
      if (obs !== 20'h0) begin
        n_bad++;
        $display("FAIL reset_hold got %h want 0", obs);
      end
    end
    rst_n_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(k <= 2 ? 4'b1111 : IDLE);
      n_cmp++;
      if ((rise_o | fall_o | pulse_o | long_o) !== 4'h0 ||
          level_o[3] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_release k=%0d got %h want quiet",
                 k, obs);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    for (int k = 1; k <= 8; k++) begin
      tick(4'b1001);
      n_cmp++;
      if (level_o[0] !== (k >= 6) || rise_o[0] !== (k == 6) ||
          pulse_o[0] !== (k == 6)) begin
        n_bad++;
        $display("FAIL press k=%0d got lvl%b r%b p%b", k,
                 level_o[0], rise_o[0], pulse_o[0]);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL press_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
    for (int k = 1; k <= 8; k++) begin
      tick(IDLE);
      n_cmp++;
      if (level_o[0] !== (k < 6) || fall_o[0] !== (k == 6) ||
          pulse_o[0] !== (k == 6)) begin
        n_bad++;
        $display("FAIL release k=%0d got lvl%b f%b p%b", k,
                 level_o[0], fall_o[0], pulse_o[0]);
      end
    end
    settle(4);
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 13; k++) begin
      tick(k <= 3 ? 4'b1010 : IDLE);
      n_cmp++;
      if (level_o[1] !== 1'b0 || rise_o[1] !== 1'b0 ||
          pulse_o[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch k=%0d got lvl%b r%b p%b", k,
                 level_o[1], rise_o[1], pulse_o[1]);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_long_press();
    int rise_k, long_k, n_long, e;
    rise_k = -1; long_k = -1; n_long = 0;
    for (int k = 1; k <= 35; k++) begin
      tick(4'b1100);
      if (rise_o[2]) rise_k = k;
      if (long_o[2]) begin
        n_long++; long_k = k;
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL long_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
    n_cmp++;
    if (n_long !== 1 || rise_k < 0 || long_k - rise_k !== L) begin
      n_bad++;
      $display("FAIL long_once got n=%0d dist=%0d want 1/%0d",
               n_long, long_k - rise_k, L);
    end
    settle(10);
    e = 0;
    for (int k = 1; k <= 20 && e == 0; k++) begin
      tick(4'b1100);
      if (rise_o[2]) e = k;
    end
    n_cmp++;
    if (e == 0) begin
      n_bad++;
      $display("FAIL long_rerun_rise got none want rise");
    end
    for (int k = 1; k <= 16; k++) begin
      tick(k <= 4 ? 4'b1100 : IDLE);
      n_cmp++;
      if (long_o[2] !== 1'b0 || level_o[2] !== (k < 10)) begin
        n_bad++;
        $display("FAIL long_cancel k=%0d got long%b lvl%b",
                 k, long_o[2], level_o[2]);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL cancel_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] pat [3];
    logic [3:0] want [3];
    pat[0] = 4'b1011; want[0] = 4'b0011;
    pat[1] = 4'b0011; want[1] = 4'b1000;
    pat[2] = IDLE;    want[2] = 4'b1011;
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 8; k++) begin
        tick(pat[p]);
        n_cmp++;
        if ((p < 2 ? rise_o : fall_o) !==
            (k == 6 ? want[p] : 4'b0000)) begin
          n_bad++;
          $display("FAIL simul p=%0d k=%0d got r%b f%b", p, k,
                   rise_o, fall_o);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
          n_bad++;
          $display("FAIL simul_model k=%0d got %h want %h",
                   k, obs, exp_vec());
        end
      end
    end
    settle(4);
  endtask

  task automatic test_reset_mid();
    int e;
    e = 0;
    for (int k = 1; k <= 20 && e == 0; k++) begin
      tick(4'b1100);
      if (rise_o[2]) e = k;
    end
    tick(4'b1100);
    for (int k = 0; k < 4; k++) tick(4'b1101);
    n_cmp++;
    if (level_o[2] !== 1'b1 || e == 0) begin
      n_bad++;
      $display("FAIL mid_pre got lvl%b want 1", level_o[2]);
    end
    #2 rst_n_i = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if (obs !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_async got %h want 0", obs);
    end
    tick(4'b1101);
    tick(4'b1101);
    rst_n_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(4'b1101);
      n_cmp++;
      if (level_o[0] !== (k >= 6) || level_o[2] !== (k >= 6)) begin
        n_bad++;
        $display("FAIL mid_latency k=%0d got lvl%b", k, level_o);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL mid_model k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
    settle(10);
  endtask

  task automatic test_random();
    logic [3:0] b;
    b = IDLE;
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(5) == 0) b[c] = ~b[c];
      tick(b);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_bad++;
        $display("FAIL random k=%0d got %h want %h",
                 k, obs, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    button_i = IDLE;
    m_reset();
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
